// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I sequencer FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction plus memory wait cycles.
// Stalls on imem_ready/dmem_ready, TIMEOUT_CYC watchdog raises bus_err; define MC_MULDIV_EN to add MDWAIT sequencing for M-extension ops.
module multicycle_controller #(
  parameter int ALU_CODE_W  = 5,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  md_done,
  output logic                  imem_req,
  output logic                  ir_we,
  output logic                  pc_we,
  output logic                  PCsel,
  output logic [2:0]            o_mem_read,
  output logic [1:0]            o_mem_write,
  output logic [1:0]            o_Wb_sel,
  output logic                  ALU_a_source,
  output logic                  ALU_b_source,
  output logic [2:0]            imm_type,
  output logic [ALU_CODE_W-1:0] alu_code,
  output logic                  regfile_write_enable,
  output logic                  md_start,
  output logic                  retire,
  output logic                  illegal_instr,
  output logic                  bus_err,
  output logic [2:0]            state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_MDWAIT = 3'd5;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = ALU_CODE_W'(0);
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = ALU_CODE_W'(1);
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = ALU_CODE_W'(2);
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = ALU_CODE_W'(3);
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = ALU_CODE_W'(4);
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = ALU_CODE_W'(5);
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = ALU_CODE_W'(6);
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = ALU_CODE_W'(7);
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = ALU_CODE_W'(8);
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = ALU_CODE_W'(9);
  localparam logic [ALU_CODE_W-1:0] ALU_LUI  = ALU_CODE_W'(10);

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [2:0] MEM_READ_NONE   = 3'd0;
  localparam logic [2:0] MEM_READ_BYTE   = 3'd1;
  localparam logic [2:0] MEM_READ_HALF   = 3'd2;
  localparam logic [2:0] MEM_READ_WORD   = 3'd3;
  localparam logic [2:0] MEM_READ_BYTE_U = 3'd4;
  localparam logic [2:0] MEM_READ_HALF_U = 3'd5;

  localparam logic [1:0] MEM_WRITE_NONE = 2'd0;
  localparam logic [1:0] MEM_WRITE_BYTE = 2'd1;
  localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
  localparam logic [1:0] MEM_WRITE_WORD = 2'd3;

  function automatic logic [ALU_CODE_W-1:0] alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_funct = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_funct = ALU_SLL;
      3'b010:  alu_from_funct = ALU_SLT;
      3'b011:  alu_from_funct = ALU_SLTU;
      3'b100:  alu_from_funct = ALU_XOR;
      3'b101:  alu_from_funct = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_funct = ALU_OR;
      default: alu_from_funct = ALU_AND;
    endcase
  endfunction

  logic [2:0]            next_state;
  logic [7:0]            wd_cnt;
  logic                  waiting, timeout;
  logic                  d_legal, d_load, d_store, d_branch, d_jump, d_md;
  logic                  d_asrc, d_bsrc;
  logic [ALU_CODE_W-1:0] d_alu;
  logic [2:0]            d_imm, d_rd;
  logic [1:0]            d_wr;

  always_comb begin
    d_legal  = 1'b0;
    d_load   = 1'b0;
    d_store  = 1'b0;
    d_branch = 1'b0;
    d_jump   = 1'b0;
    d_md     = 1'b0;
    d_alu    = ALU_ADD;
    d_imm    = IMM_NONE;
    d_asrc   = 1'b0;
    d_bsrc   = 1'b0;
    d_rd     = MEM_READ_NONE;
    d_wr     = MEM_WRITE_NONE;
    case (opcode)
      OPC_OP: begin
        d_legal = 1'b1;
        d_alu   = alu_from_funct(funct3, funct7[5]);
        if (funct7 == 7'b0000001) begin
          d_alu = ALU_ADD;
`ifdef MC_MULDIV_EN
          d_md  = 1'b1;
`endif
        end
      end
      OPC_OP_IMM: begin
        // funct7 bits belong to the immediate except on SRAI
        d_legal = 1'b1;
        d_imm   = IMM_I;
        d_bsrc  = 1'b1;
        d_alu   = alu_from_funct(funct3, (funct3 == 3'b101) && funct7[5]);
      end
      OPC_LOAD: begin
        d_legal = 1'b1;
        d_load  = 1'b1;
        d_imm   = IMM_I;
        d_bsrc  = 1'b1;
        case (funct3)
          3'b000:  d_rd = MEM_READ_BYTE;
          3'b001:  d_rd = MEM_READ_HALF;
          3'b100:  d_rd = MEM_READ_BYTE_U;
          3'b101:  d_rd = MEM_READ_HALF_U;
          default: d_rd = MEM_READ_WORD;
        endcase
      end
      OPC_STORE: begin
        d_legal = 1'b1;
        d_store = 1'b1;
        d_imm   = IMM_S;
        d_bsrc  = 1'b1;
        case (funct3[1:0])
          2'b00:   d_wr = MEM_WRITE_BYTE;
          2'b01:   d_wr = MEM_WRITE_HALF;
          default: d_wr = MEM_WRITE_WORD;
        endcase
      end
      OPC_BRANCH: begin
        d_legal  = 1'b1;
        d_branch = 1'b1;
        d_imm    = IMM_B;
        d_asrc   = 1'b1;
        d_bsrc   = 1'b1;
      end
      OPC_JAL: begin
        d_legal = 1'b1;
        d_jump  = 1'b1;
        d_imm   = IMM_J;
        d_asrc  = 1'b1;
        d_bsrc  = 1'b1;
      end
      OPC_JALR: begin
        d_legal = 1'b1;
        d_jump  = 1'b1;
        d_imm   = IMM_I;
        d_bsrc  = 1'b1;
      end
      OPC_LUI: begin
        d_legal = 1'b1;
        d_imm   = IMM_U;
        d_bsrc  = 1'b1;
        d_alu   = ALU_LUI;
      end
      OPC_AUIPC: begin
        d_legal = 1'b1;
        d_imm   = IMM_U;
        d_asrc  = 1'b1;
        d_bsrc  = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
  end

  // IR contents are stale during FETCH, so datapath selects stay quiet there
  assign alu_code     = (state != S_FETCH) ? d_alu  : '0;
  assign imm_type     = (state != S_FETCH) ? d_imm  : IMM_NONE;
  assign ALU_a_source = (state != S_FETCH) && d_asrc;
  assign ALU_b_source = (state != S_FETCH) && d_bsrc;

  assign waiting = ((state == S_FETCH) && !imem_ready) || ((state == S_MEM) && !dmem_ready);
  assign timeout = waiting && (wd_cnt == 8'(TIMEOUT_CYC - 1));

  always_comb begin
    next_state           = state;
    imem_req             = 1'b0;
    ir_we                = 1'b0;
    pc_we                = 1'b0;
    PCsel                = 1'b0;
    o_mem_read           = MEM_READ_NONE;
    o_mem_write          = MEM_WRITE_NONE;
    o_Wb_sel             = 2'b00;
    regfile_write_enable = 1'b0;
    md_start             = 1'b0;
    retire               = 1'b0;
    illegal_instr        = 1'b0;
    bus_err              = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = !timeout;
        if (imem_ready) begin
          ir_we      = 1'b1;
          next_state = S_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        if (!d_legal) begin
          illegal_instr = 1'b1;
          pc_we         = 1'b1;
          retire        = 1'b1;
          next_state    = S_FETCH;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (d_branch) begin
          pc_we      = 1'b1;
          PCsel      = branch_taken;
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (d_jump) begin
          regfile_write_enable = 1'b1;
          o_Wb_sel             = 2'b10;
          pc_we                = 1'b1;
          PCsel                = 1'b1;
          retire               = 1'b1;
          next_state           = S_FETCH;
        end else if (d_load || d_store) begin
          next_state = S_MEM;
        end else if (d_md) begin
          md_start   = 1'b1;
          next_state = S_MDWAIT;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        o_mem_read  = timeout ? MEM_READ_NONE  : d_rd;
        o_mem_write = timeout ? MEM_WRITE_NONE : d_wr;
        if (dmem_ready) begin
          if (d_load) begin
            next_state = S_WB;
          end else begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
        end else if (timeout) begin
          bus_err    = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_WB: begin
        regfile_write_enable = 1'b1;
        pc_we                = 1'b1;
        retire               = 1'b1;
        o_Wb_sel             = d_load ? 2'b01 : (d_md ? 2'b11 : 2'b00);
        next_state           = S_FETCH;
      end
      S_MDWAIT: begin
`ifdef MC_MULDIV_EN
        if (md_done) next_state = S_WB;
`else
        next_state = S_FETCH;
`endif
      end
      default: next_state = S_FETCH;
    endcase
  end

`ifndef MC_MULDIV_EN
  logic unused_md_done;
  assign unused_md_done = md_done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      wd_cnt <= 8'd0;
    end else begin
      state <= next_state;
      // Every state change (or a timeout retry in FETCH) restarts the wait count
      if ((next_state != state) || timeout) begin
        wd_cnt <= 8'd0;
      end else if (waiting) begin
        wd_cnt <= wd_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: decode table per opcode plus hand sequences for waits, timeouts, reset and mul/div.
module tb_multicycle_controller;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       branch_taken, imem_ready, dmem_ready, md_done;
  logic       imem_req, ir_we, pc_we, PCsel;
  logic [2:0] o_mem_read;
  logic [1:0] o_mem_write, o_Wb_sel;
  logic       ALU_a_source, ALU_b_source;
  logic [2:0] imm_type;
  logic [4:0] alu_code;
  logic       regfile_write_enable, md_start, retire, illegal_instr, bus_err;
  logic [2:0] state;

  multicycle_controller #(.ALU_CODE_W(5), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .md_done(md_done), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .PCsel(PCsel),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_Wb_sel(o_Wb_sel),
    .ALU_a_source(ALU_a_source), .ALU_b_source(ALU_b_source), .imm_type(imm_type),
    .alu_code(alu_code), .regfile_write_enable(regfile_write_enable), .md_start(md_start),
    .retire(retire), .illegal_instr(illegal_instr), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int alu, imm, asrc, bsrc, rd, wr, cyc, wb, rfwe, pcsel, ill;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  int cyc, n_ret, n_pcwe, n_rfwe, n_berr, n_ill, n_mds, n_rdcyc, n_memcyc, n_mdw, ber_cyc;
  int mis = 0;
  int leak = 0;
  int c_alu, c_imm, c_asrc, c_bsrc, c_rd, c_wr, r_wb, r_pcsel, r_rfwe;
  int st_tr[16];
  bit run_done;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic addv(input string n, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input int alu, input int imm, input int a, input int b, input int rd, input int wr,
                      input int cy, input int wb, input int rf, input int pcs, input int ill);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7;
    v.alu = alu; v.imm = imm; v.asrc = a; v.bsrc = b; v.rd = rd; v.wr = wr;
    v.cyc = cy; v.wb = wb; v.rfwe = rf; v.pcsel = pcs; v.ill = ill;
    vecs.push_back(v);
  endtask

  // Runs one instruction from FETCH until retire or bus_err; ready lines rise after iw/dw/mw wait cycles.
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input int iw, input int dw, input int mw, input logic bt);
    int fc, mc;
    cyc = 0; n_ret = 0; n_pcwe = 0; n_rfwe = 0; n_berr = 0; n_ill = 0; n_mds = 0;
    n_rdcyc = 0; n_memcyc = 0; n_mdw = 0; ber_cyc = 0;
    c_alu = 0; c_imm = 0; c_asrc = 0; c_bsrc = 0; c_rd = 0; c_wr = 0;
    r_wb = 0; r_pcsel = 0; r_rfwe = 0;
    for (int i = 0; i < 16; i++) st_tr[i] = -1;
    fc = 0; mc = 0;
    opcode = op; funct3 = f3; funct7 = f7; branch_taken = bt;
    imem_ready = (iw == 0); dmem_ready = (dw == 0); md_done = (mw == 0);
    run_done = 1'b0;
    for (int i = 0; i < 40 && !run_done; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc <= 16) st_tr[cyc-1] = int'(state);
      if (state == 3'd2) begin
        c_alu = int'(alu_code); c_imm = int'(imm_type);
        c_asrc = int'(ALU_a_source); c_bsrc = int'(ALU_b_source);
      end
      if (o_mem_read != 3'd0) begin n_rdcyc++; c_rd = int'(o_mem_read); end
      if (o_mem_write != 2'd0) c_wr = int'(o_mem_write);
      if (pc_we) n_pcwe++;
      if (regfile_write_enable) n_rfwe++;
      if (md_start) n_mds++;
      if (illegal_instr) n_ill++;
      if (pc_we != retire) mis++;
      if (state == 3'd0 && (alu_code != 5'd0 || imm_type != 3'd0 || o_mem_read != 3'd0 ||
                            o_mem_write != 2'd0 || regfile_write_enable || pc_we)) leak++;
      if (retire) begin
        n_ret++; r_wb = int'(o_Wb_sel); r_pcsel = int'(PCsel); r_rfwe = int'(regfile_write_enable);
        run_done = 1'b1;
      end
      if (bus_err) begin n_berr++; ber_cyc = cyc; run_done = 1'b1; end
      if (state == 3'd0) fc++;
      if (state == 3'd3) begin mc++; n_memcyc++; end
      if (state == 3'd5) n_mdw++;
      @(posedge clk); #1;
      imem_ready = (fc >= iw); dmem_ready = (mc >= dw); md_done = (n_mdw >= mw);
    end
    chk("run_bound", int'(run_done), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    //   name     opcode      f3      f7          alu imm a b rd wr cyc wb rf pcs ill
    addv("add",   OPC_OP,     3'b000, 7'b0000000,  0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0);
    addv("sub",   OPC_OP,     3'b000, 7'b0100000,  1, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0);
    addv("sra",   OPC_OP,     3'b101, 7'b0100000,  7, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0);
    addv("xor",   OPC_OP,     3'b100, 7'b0000000,  5, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0);
    addv("sltu",  OPC_OP,     3'b011, 7'b0000000,  4, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0);
    addv("srli",  OPC_OP_IMM, 3'b101, 7'b0000000,  6, 1, 0, 1, 0, 0, 4, 0, 1, 0, 0);
    addv("srai",  OPC_OP_IMM, 3'b101, 7'b0100000,  7, 1, 0, 1, 0, 0, 4, 0, 1, 0, 0);
    addv("andi",  OPC_OP_IMM, 3'b111, 7'b0000000,  9, 1, 0, 1, 0, 0, 4, 0, 1, 0, 0);
    addv("addi_n",OPC_OP_IMM, 3'b000, 7'b0100000,  0, 1, 0, 1, 0, 0, 4, 0, 1, 0, 0);
    addv("lw",    OPC_LOAD,   3'b010, 7'b0000000,  0, 1, 0, 1, 3, 0, 5, 1, 1, 0, 0);
    addv("lbu",   OPC_LOAD,   3'b100, 7'b0000000,  0, 1, 0, 1, 4, 0, 5, 1, 1, 0, 0);
    addv("sw",    OPC_STORE,  3'b010, 7'b0000000,  0, 2, 0, 1, 0, 3, 4, 0, 0, 0, 0);
    addv("sb",    OPC_STORE,  3'b000, 7'b0000000,  0, 2, 0, 1, 0, 1, 4, 0, 0, 0, 0);
    addv("beq",   OPC_BRANCH, 3'b000, 7'b0000000,  0, 3, 1, 1, 0, 0, 3, 0, 0, 0, 0);
    addv("jal",   OPC_JAL,    3'b000, 7'b0000000,  0, 5, 1, 1, 0, 0, 3, 2, 1, 1, 0);
    addv("jalr",  OPC_JALR,   3'b000, 7'b0000000,  0, 1, 0, 1, 0, 0, 3, 2, 1, 1, 0);
    addv("lui",   OPC_LUI,    3'b000, 7'b0000000, 10, 4, 0, 1, 0, 0, 4, 0, 1, 0, 0);
    addv("auipc", OPC_AUIPC,  3'b000, 7'b0000000,  0, 4, 1, 1, 0, 0, 4, 0, 1, 0, 0);
    addv("illeg", 7'b1111111, 3'b000, 7'b0000000,  0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);
`ifndef MC_MULDIV_EN
    addv("div_nm",OPC_OP,     3'b100, 7'b0000001,  0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0);
`endif

    // Reset with a load sitting in the IR: only imem_req may be high
    rst_n = 1'b0; opcode = OPC_LOAD; funct3 = 3'b010; funct7 = 7'd0;
    branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; md_done = 1'b0;
    #12;
    chk("rst.state", int'(state), 0);
    chk("rst.imem_req", int'(imem_req), 1);
    chk("rst.ir_we", int'(ir_we), 0);
    chk("rst.pc_we", int'(pc_we), 0);
    chk("rst.rfwe", int'(regfile_write_enable), 0);
    chk("rst.mem_read", int'(o_mem_read), 0);
    chk("rst.imm_type", int'(imm_type), 0);
    chk("rst.b_src", int'(ALU_b_source), 0);
    chk("rst.retire", int'(retire), 0);
    chk("rst.bus_err", int'(bus_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run(vecs[k].op, vecs[k].f3, vecs[k].f7, 0, 0, 0, 1'b0);
      chk({vecs[k].name, ".alu"},    c_alu,   vecs[k].alu);
      chk({vecs[k].name, ".imm"},    c_imm,   vecs[k].imm);
      chk({vecs[k].name, ".asrc"},   c_asrc,  vecs[k].asrc);
      chk({vecs[k].name, ".bsrc"},   c_bsrc,  vecs[k].bsrc);
      chk({vecs[k].name, ".rd"},     c_rd,    vecs[k].rd);
      chk({vecs[k].name, ".wr"},     c_wr,    vecs[k].wr);
      chk({vecs[k].name, ".cycles"}, cyc,     vecs[k].cyc);
      chk({vecs[k].name, ".wb_sel"}, r_wb,    vecs[k].wb);
      chk({vecs[k].name, ".rfwe"},   n_rfwe,  vecs[k].rfwe);
      chk({vecs[k].name, ".pcsel"},  r_pcsel, vecs[k].pcsel);
      chk({vecs[k].name, ".ill"},    n_ill,   vecs[k].ill);
      chk({vecs[k].name, ".retire"}, n_ret,   1);
      chk({vecs[k].name, ".md_st"},  n_mds,   0);
    end

    // add: state walk and write only in WB
    run(OPC_OP, 3'b000, 7'd0, 0, 0, 0, 1'b0);
    chk("add.st0", st_tr[0], 0);
    chk("add.st1", st_tr[1], 1);
    chk("add.st2", st_tr[2], 2);
    chk("add.st3", st_tr[3], 4);
    chk("add.rfwe_at_retire", r_rfwe, 1);
    chk("add.rfwe_count", n_rfwe, 1);

    // lw with dmem_ready three cycles late
    run(OPC_LOAD, 3'b010, 7'd0, 0, 3, 0, 1'b0);
    chk("lw_wait.rd_cycles", n_rdcyc, 4);
    chk("lw_wait.rd_enc", c_rd, 3);
    chk("lw_wait.cycles", cyc, 8);
    chk("lw_wait.wb_sel", r_wb, 1);

    // beq taken, bne not taken
    run(OPC_BRANCH, 3'b000, 7'd0, 0, 0, 0, 1'b1);
    chk("beq_t.pcsel", r_pcsel, 1);
    chk("beq_t.pcwe", n_pcwe, 1);
    chk("beq_t.rfwe", n_rfwe, 0);
    chk("beq_t.cycles", cyc, 3);
    run(OPC_BRANCH, 3'b001, 7'd0, 0, 0, 0, 1'b0);
    chk("bne_nt.pcsel", r_pcsel, 0);
    chk("bne_nt.pcwe", n_pcwe, 1);
    chk("bne_nt.rfwe", n_rfwe, 0);

    // Fetch timeout on the 4th wait cycle, then ready arriving exactly on that cycle
    run(OPC_OP, 3'b000, 7'd0, 100, 0, 0, 1'b0);
    chk("ftmo.bus_err", n_berr, 1);
    chk("ftmo.err_cycle", ber_cyc, 4);
    chk("ftmo.retire", n_ret, 0);
    chk("ftmo.pcwe", n_pcwe, 0);
    chk("ftmo.state_after", int'(state), 0);
    run(OPC_OP, 3'b000, 7'd0, 3, 0, 0, 1'b0);
    chk("fedge.bus_err", n_berr, 0);
    chk("fedge.retire", n_ret, 1);
    chk("fedge.cycles", cyc, 7);

    // Data timeout during a load: no write-back, back to FETCH
    run(OPC_LOAD, 3'b010, 7'd0, 0, 100, 0, 1'b0);
    chk("mtmo.bus_err", n_berr, 1);
    chk("mtmo.err_cycle", ber_cyc, 7);
    chk("mtmo.rfwe", n_rfwe, 0);
    chk("mtmo.retire", n_ret, 0);
    chk("mtmo.state_after", int'(state), 0);
    run(OPC_OP, 3'b000, 7'd0, 0, 0, 0, 1'b0);
    chk("after_mtmo.cycles", cyc, 4);

    // Reset dropped while a store waits in MEM
    opcode = OPC_STORE; funct3 = 3'b010; funct7 = 7'd0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    run_done = 1'b0;
    for (int i = 0; i < 10 && !run_done; i++) begin
      @(negedge clk);
      if (state == 3'd3) run_done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("sw_rst.reach_mem", int'(run_done), 1);
    chk("sw_rst.mem_write", int'(o_mem_write), 3);
    chk("sw_rst.pcwe_pre", int'(pc_we), 0);
    #1 rst_n = 1'b0;
    #1;
    chk("sw_rst.async_wr", int'(o_mem_write), 0);
    chk("sw_rst.async_state", int'(state), 0);
    chk("sw_rst.async_pcwe", int'(pc_we), 0);
    chk("sw_rst.async_rfwe", int'(regfile_write_enable), 0);
    @(posedge clk); #1;
    chk("sw_rst.hold_pcwe", int'(pc_we), 0);
    rst_n = 1'b1;
    chk("sw_rst.state_after", int'(state), 0);
    run(OPC_OP, 3'b000, 7'd0, 0, 0, 0, 1'b0);
    chk("sw_rst.next_cycles", cyc, 4);

`ifdef MC_MULDIV_EN
    run(OPC_OP, 3'b000, 7'b0000001, 0, 0, 5, 1'b0);
    chk("mul.md_start", n_mds, 1);
    chk("mul.mdwait", n_mdw, 6);
    chk("mul.wb_sel", r_wb, 3);
    chk("mul.rfwe", n_rfwe, 1);
    chk("mul.cycles", cyc, 10);
`endif

    chk("pcwe_eq_retire", mis, 0);
    chk("fetch_dp_idle", leak, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle successor to the single-cycle RV32I controller. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the same datapath control set (`alu_code`, `imm_type`, ALU source selects, `o_Wb_sel`, `o_mem_read`/`o_mem_write`, `PCsel`) only in the state where each is consumed. It adds ready-handshakes to instruction and data memory with a bus-timeout watchdog, plus optional M-extension sequencing. It sits between the PC/IR registers and the shared ALU/regfile/memory datapath.

## Interface
- `ALU_CODE_W`, 5, width of `alu_code`; encodings are the `ALU_*` macros in Defines.vh.
- `TIMEOUT_CYC`, 15, maximum wait cycles on `imem_ready`/`dmem_ready` before `bus_err`; range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  from the latched IR.
- `funct3`  in  3  from the latched IR.
- `funct7`  in  7  from the latched IR.
- `branch_taken`  in  1  comparator result; sampled in EXEC.
- `imem_ready`  in  1  instruction word valid this cycle.
- `dmem_ready`  in  1  data access complete this cycle.
- `md_done`  in  1  mul/div unit result valid (`MC_MULDIV_EN` only).
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  IR load strobe.
- `pc_we`  out  1  PC update strobe.
- `PCsel`  out  1  0: PC+4, 1: ALU result.
- `o_mem_read`  out  3  `MEM_READ_*` encoding.
- `o_mem_write`  out  2  `MEM_WRITE_*` encoding.
- `o_Wb_sel`  out  2  00: ALU, 01: memory, 10: PC+4, 11: mul/div.
- `ALU_a_source`  out  1  ALU operand A select.
- `ALU_b_source`  out  1  ALU operand B select.
- `imm_type`  out  3  `IMM_*` encoding.
- `alu_code`  out  `ALU_CODE_W`  ALU operation.
- `regfile_write_enable`  out  1  register-file write strobe.
- `md_start`  out  1  one-cycle mul/div start pulse.
- `retire`  out  1  one-cycle pulse, coincident with the instruction's `pc_we`.
- `illegal_instr`  out  1  one-cycle pulse in DECODE on an unknown opcode.
- `bus_err`  out  1  one-cycle pulse on timeout.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5.

## Operation
- Decode (`alu_code`, `imm_type`, source selects, `o_mem_read`/`o_mem_write` encodings, branch flags) is combinational from `opcode`/`funct3`/`funct7`, with the same mapping as the single-cycle controller. Strobes are gated by state.
- FETCH: `imem_req`=1. On `imem_ready`, assert `ir_we` and go to DECODE.
- DECODE: go to EXEC. On an unknown opcode, pulse `illegal_instr`; the instruction is then treated as a NOP (`pc_we`=1, `PCsel`=0, `retire`=1) and the FSM returns to FETCH.
- EXEC, by instruction class:
  - BRANCH: `pc_we`=1, `PCsel`=`branch_taken`, `retire`; go to FETCH.
  - JAL/JALR: `regfile_write_enable`=1, `o_Wb_sel`=10, `pc_we`=1, `PCsel`=1, `retire`; go to FETCH.
  - LOAD/STORE: go to MEM.
  - OP/OP_IMM/LUI/AUIPC: go to WB.
- MEM: `o_mem_read` or `o_mem_write` is held non-zero until `dmem_ready`.
  - Load completes: go to WB with `o_Wb_sel`=01.
  - Store completes: `pc_we`, `PCsel`=0, `retire`; go to FETCH.
- WB: `regfile_write_enable`=1, `pc_we`=1, `PCsel`=0, `retire`; go to FETCH.
- Every strobe (`ir_we`, `pc_we`, `regfile_write_enable`, memory enables, `md_start`, pulses) is 0 outside the states listed above.
- Watchdog: an 8-bit counter clears on entry to FETCH/MEM and increments on each waiting cycle.
  - If it reaches `TIMEOUT_CYC` with ready still low: pulse `bus_err`, drop the request, no `pc_we`, return to FETCH (the same PC is re-fetched).
  - If ready arrives in the same cycle the count reaches `TIMEOUT_CYC`, it is a success, not an error.
- Reset mid-operation: any in-flight state is abandoned with no `pc_we` or `regfile_write_enable`.

## Timing
- Reset values: `state`=FETCH, counter=0. Every output is 0 except `imem_req`, which is 1 (FETCH).
- Cycle counts with zero-wait memories:
  - Branch/JAL/JALR: 3 cycles.
  - ALU, LUI, AUIPC, store: 4 cycles.
  - Load: 5 cycles.
- Each wait cycle adds 1.
- Exactly one `retire` per completed instruction; none on `bus_err`.

## Configuration
- `MC_MULDIV_EN` defined:
  - OP with `funct7`=0000001 is an M-extension instruction.
  - EXEC pulses `md_start` and goes to MDWAIT.
  - MDWAIT holds until `md_done`, then goes to WB with `o_Wb_sel`=11.
  - MDWAIT is not watchdogged.
- `MC_MULDIV_EN` undefined: such encodings fall into the single-cycle controller's OP default (`ALU_ADD`, plain WB). MDWAIT is unreachable and `md_start` is tied to 0.

## Test plan
- `add x3,x1,x2` with `imem_ready` held 1 → `state` 0,1,2,4. `regfile_write_enable` and `retire` assert only in cycle 4, with `alu_code`=`ALU_ADD`.
- `lw` with `dmem_ready` delayed 3 cycles → `o_mem_read`=`MEM_READ_WORD` for 4 MEM cycles, WB with `o_Wb_sel`=01, 8 cycles total.
- `beq` with `branch_taken`=1, then `bne` with `branch_taken`=0 → `pc_we` in EXEC with `PCsel` 1, then 0. No regfile write in either.
- `imem_ready` held low, `TIMEOUT_CYC`=4 → `bus_err` pulse on the 4th wait cycle, no `retire`, `state` stays FETCH. With ready on exactly that cycle → no `bus_err`.
- `rst_n` dropped during MEM of `sw` → all strobes 0 asynchronously. After release `state`=0 and no write has occurred.
- With `MC_MULDIV_EN`, `mul` and `md_done` after 6 cycles → one `md_start` pulse, 6 MDWAIT cycles, WB with `o_Wb_sel`=11.
